// File: rtl/mul_pkg.sv
// Shared types and constants for the 2x3 time-shared multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DIG_A = 2;
    localparam int DIG_B = 3;
    localparam int PP_W  = DIG_A + DIG_B;

endpackage

// File: rtl/mul2x3_core.sv
// Combinational unsigned 2-bit x 3-bit multiplier built from an explicit
// partial-product array reduced with half/full adders.
module mul2x3_core
    import mul_pkg::*;
(
    input  logic [DIG_A-1:0] a,
    input  logic [DIG_B-1:0] b,
    output logic [PP_W-1:0]  p
);

    logic pp00, pp01, pp02, pp10, pp11, pp12;
    logic s1, c1, s2, c2, s3, c3;

    always_comb begin
        pp00 = a[0] & b[0];
        pp01 = a[0] & b[1];
        pp02 = a[0] & b[2];
        pp10 = a[1] & b[0];
        pp11 = a[1] & b[1];
        pp12 = a[1] & b[2];

        // column 1: half adder, column 2: full adder, column 3: half adder
        s1 = pp01 ^ pp10;
        c1 = pp01 & pp10;
        s2 = pp02 ^ pp11 ^ c1;
        c2 = (pp02 & pp11) | (pp02 & c1) | (pp11 & c1);
        s3 = pp12 ^ c2;
        c3 = pp12 & c2;

        p = {c3, s3, s2, s1, pp00};
    end

endmodule

// File: rtl/mul2x3_seq_sched.sv
// Unsigned W_A x W_B multiplier that walks every (A digit, B digit) pair
// through one shared 2x3 core, accumulating shifted partial products.
module mul2x3_seq_sched
    import mul_pkg::*;
#(
    parameter  int W_A    = 8,
    parameter  int W_B    = 6,
    localparam int NA     = W_A / DIG_A,
    localparam int NB     = W_B / DIG_B,
    localparam int NSTEP  = NA * NB,
    localparam int STEP_W = (NSTEP > 1) ? $clog2(NSTEP) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W_A-1:0]       a_in,
    input  logic [W_B-1:0]       b_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W_A+W_B-1:0]   product,
    output logic                 busy,
    output logic [STEP_W-1:0]    step
);

    localparam int P_W  = W_A + W_B;
    localparam int IA_W = (NA > 1) ? $clog2(NA) : 1;
    localparam int JB_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int SH_W = $clog2(P_W);

    state_e            state_q, state_d;
    logic [W_A-1:0]    a_q, a_d;
    logic [W_B-1:0]    b_q, b_d;
    logic [P_W-1:0]    acc_q, acc_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [IA_W-1:0]   i_q, i_d;
    logic [JB_W-1:0]   j_q, j_d;

    logic              accept;
    logic              last_step;
    logic [DIG_A-1:0]  a_sel;
    logic [DIG_B-1:0]  b_sel;
    logic [PP_W-1:0]   pp;
    logic [SH_W-1:0]   sh;

    // Digit views of the latched operands; i_q/j_q select one of each.
    logic [DIG_A-1:0] a_dig [NA];
    logic [DIG_B-1:0] b_dig [NB];

    for (genvar k = 0; k < NA; k++) begin : g_adig
        assign a_dig[k] = a_q[DIG_A*k +: DIG_A];
    end
    for (genvar k = 0; k < NB; k++) begin : g_bdig
        assign b_dig[k] = b_q[DIG_B*k +: DIG_B];
    end

    assign a_sel = a_dig[i_q];
    assign b_sel = b_dig[j_q];

    mul2x3_core u_core (
        .a (a_sel),
        .b (b_sel),
        .p (pp)
    );

    assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign last_step = (step_q == STEP_W'(NSTEP - 1));
    assign sh        = SH_W'(DIG_A * int'(i_q) + DIG_B * int'(j_q));

    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN);
    assign product   = acc_q;
    assign step      = step_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        step_d  = step_q;
        i_d     = i_q;
        j_d     = j_q;

        case (state_q)
            IDLE: if (accept) state_d = RUN;
            RUN:  if (last_step) state_d = DONE;
            DONE: if (out_ready) state_d = accept ? RUN : IDLE;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            a_d    = a_in;
            b_d    = b_in;
            acc_d  = '0;
            step_d = '0;
            i_d    = '0;
            j_d    = '0;
        end else if (state_q == RUN) begin
            acc_d = acc_q + (P_W'(pp) << sh);
            // A digits form the inner loop; counters park at 0 after the last step
            if (last_step) begin
                step_d = '0;
                i_d    = '0;
                j_d    = '0;
            end else begin
                step_d = step_q + 1'b1;
                if (i_q == IA_W'(NA - 1)) begin
                    i_d = '0;
                    j_d = j_q + 1'b1;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            step_q  <= '0;
            i_q     <= '0;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            step_q  <= step_d;
            i_q     <= i_d;
            j_q     <= j_d;
        end
    end

endmodule

// File: doc/mul2x3_seq_sched.md
# mul2x3_seq_sched

Sequential scheduler that computes an unsigned W_A × W_B product by time-sharing one combinational 2-bit × 3-bit multiplier core. Each cycle it feeds one (2-bit A digit, 3-bit B digit) pair to the core and accumulates the shifted 5-bit partial product. It sits between a valid/ready producer of operand pairs and a valid/ready consumer of products. It is the area-lean alternative to a full-width Wallace/CLA array multiplier.

## Interface
Parameters:
- W_A, 8: multiplicand width. Must be even and ≥2; NA = W_A/2 digits.
- W_B, 6: multiplier width. Must be a multiple of 3 and ≥3; NB = W_B/3 digits.
- NSTEP (derived), NA*NB: cycles per operation.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  block can accept an operand pair (combinational).
- a_in  in  W_A  multiplicand, unsigned.
- b_in  in  W_B  multiplier, unsigned.
- out_valid  out  1  product available.
- out_ready  in  1  consumer accepts the product.
- product  out  W_A+W_B  unsigned product; meaningful only while out_valid=1.
- busy  out  1  state is RUN.
- step  out  clog2(NSTEP) (min 1)  current step index (debug).

## Operation
- FSM states:
  - IDLE → RUN on accept.
  - RUN → DONE on the edge that executes step NSTEP-1.
  - DONE → IDLE on an output handshake with no new accept.
  - DONE → RUN on an output handshake with a simultaneous accept.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Accept = in_valid & in_ready.
- On accept:
  - Latch a_in and b_in into operand registers.
  - Clear the accumulator to 0.
  - Set step to 0.
- RUN step s:
  - i = s mod NA, j = s div NA (A digits inner loop, B digits outer loop).
  - The core computes pp = A[2i+1:2i] × B[3j+2:3j], a 5-bit value with max 21.
  - acc += pp << (2i+3j).
  - step increments.
- The accumulator is W_A+W_B bits wide. The sum never exceeds the final product, so no overflow or wrap is possible.
- product is driven directly from the accumulator. It holds stable throughout DONE.
- out_valid = (state==DONE).
- Output handshake = out_valid & out_ready.
- Back-to-back operation: when out_ready=1 and in_valid=1 in DONE, the output handshake and the new accept occur on the same edge. The accumulator then clears for the new operation, and the old product is considered consumed.
- in_valid while busy: ignored (in_ready=0). The producer must hold its data until accepted.
- Asynchronous reset at any time, including mid-RUN: the in-flight operation is discarded and nothing is emitted for it.
- Reset values:
  - state IDLE; accumulator 0; operand registers 0; step 0.
  - out_valid 0; busy 0; product 0.
  - in_ready 1 (IDLE).

## Timing
- Accept on edge E0. RUN steps execute on edges E0+1 … E0+NSTEP.
- out_valid is high from just after edge E0+NSTEP. Latency is NSTEP edges after the accept edge; 8 edges at the defaults.
- Throughput is one product per NSTEP+1 cycles with back-to-back handshakes, which is the minimum.
- out_valid, product and busy are registered-state outputs.
- in_ready is the only combinational output. It depends on out_ready, which is a legal valid/ready path. No in_valid → in_ready path exists.
- busy is high for exactly NSTEP cycles per operation.

## Structure
- Shared package mul_pkg holds:
  - The state enum {IDLE, RUN, DONE}.
  - DIG_A=2 and DIG_B=3 constants.
  - The PP_W=5 constant.
- Sub-module mul2x3_core: purely combinational unsigned 2×3 → 5-bit multiplier. It uses a partial-product/half-full-adder reduction and is instantiated once.
- The scheduler holds:
  - The FSM.
  - The step counter with i/j decode.
  - Digit mux.
  - Shifter and accumulator.

## Test plan
- Defaults: a_in=0xFF, b_in=0x3F, out_ready=1.
  - Expect product=0x3EC1 (16065).
  - out_valid rises exactly 8 edges after accept.
  - busy is high for 8 cycles.
- a_in=0x00 with b_in=0x2A, then a_in=0xA5 with b_in=0x00.
  - Expect product=0 for both operations, with the same latency.
- Backpressure: a_in=0x12, b_in=0x07, out_ready held low for 5 cycles after out_valid.
  - product holds 0x07E (126) and out_valid stays high.
  - in_ready stays 0 while in_valid=1 is offered.
  - The product is consumed on the first out_ready=1 edge.
- Back-to-back: with in_valid=1 and out_ready=1 continuous, stream (3,5), (200,63), (1,1).
  - Expect products 15, 12600 and 1.
  - Spacing is exactly 9 cycles between out_valid pulses.
  - No transaction is lost or duplicated.
- Reset mid-operation: assert rst asynchronously during step 4 of (0xFF,0x3F).
  - Immediately: out_valid=0, busy=0, in_ready=1, product=0.
  - The next operation (0x0F,0x05) yields 75.
- Parameter sweep W_A=4, W_B=3 (NSTEP=2): exhaustive 16×8 operands.
  - All products equal a×b.
  - Latency is 2 edges.
